// File: rtl/fifo_rd_ctrl_pkg.sv
// fifo_rd_ctrl_pkg: state encoding and latency limit shared by the TX FIFO read sequencer
package fifo_rd_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, VALID, FLUSH} state_e;
   localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: fetches FIFO words through a latent RAM port and hands them to the UART TX over valid/ready; FIFO_RD_CTRL_CNT_EN adds the o_xfer_cnt handshake counter
module fifo_rd_ctrl
   import fifo_rd_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic              i_flush,
   output logic              o_fifo_ren,
   input  logic              i_fifo_rempty,
   input  logic [DATA_W-1:0] i_fifo_rdata,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy
`ifdef FIFO_RD_CTRL_CNT_EN
   ,
   output logic [CNT_W-1:0]  o_xfer_cnt
`endif
);

   localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("fifo_rd_ctrl: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("fifo_rd_ctrl: CNT_W must be positive");
   end

   state_e              state_q, state_d;
   logic [1:0]          lat_q, lat_d;
   logic                flush_seen_q, flush_seen_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic                drop;

   // a flush seen anywhere in FETCH/WAIT (including the last WAIT cycle) discards the word in flight
   assign drop = flush_seen_q | i_flush;

   // next-state decode: fetch, absorb RAM latency, hold for handshake, or drain on flush
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      flush_seen_d = flush_seen_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      case (state_q)
         IDLE:    state_d = i_flush ? FLUSH : (i_enable & ~i_fifo_rempty) ? FETCH : IDLE;
         FETCH: begin
            lat_d        = LAT_LOAD;
            flush_seen_d = i_flush;
            state_d      = WAIT;
         end
         WAIT: begin
            flush_seen_d = drop;
            lat_d        = (lat_q == 2'd0) ? lat_q : lat_q - 2'd1;
            tx_data_d    = (lat_q == 2'd0 && !drop) ? i_fifo_rdata : tx_data_q;
            tx_valid_d   = (lat_q == 2'd0) & ~drop;
            state_d      = (lat_q != 2'd0) ? WAIT : drop ? FLUSH : VALID;
         end
         VALID: begin
            tx_valid_d = ~(i_flush | i_tx_ready);
            state_d    = i_flush ? FLUSH : !i_tx_ready ? VALID :
                         (i_enable & ~i_fifo_rempty) ? FETCH : IDLE;
         end
         FLUSH:   state_d = i_flush ? FLUSH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and registered transmitter outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lat_q        <= 2'd0;
         flush_seen_q <= 1'b0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         flush_seen_q <= flush_seen_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
      end
   end

   assign o_fifo_ren = (state_q == FETCH) | ((state_q == FLUSH) & ~i_fifo_rempty);
   assign o_busy     = state_q != IDLE;
   assign o_tx_data  = tx_data_q;
   assign o_tx_valid = tx_valid_q;

`ifdef FIFO_RD_CTRL_CNT_EN
   logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

   // count accepted handshakes; a same-cycle flush pre-empts the transfer
   always_comb begin
      xfer_cnt_d = xfer_cnt_q + ((state_q == VALID && i_tx_ready && !i_flush) ? CNT_W'(1) : CNT_W'(0));
   end

   // transfer counter register
   always_ff @(posedge clk) begin
      if (rst) xfer_cnt_q <= '0;
      else     xfer_cnt_q <= xfer_cnt_d;
   end

   assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and randomized checks of fifo_rd_ctrl at RD_LAT=1 and RD_LAT=3 against a queue-based FIFO model and in-order scoreboard
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, flush = 1'b0, ready = 1'b0, wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   int         errs = 0, checks = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int LAT = g ? 3 : 1;
      logic       ren, tx_valid, busy;
      logic       rempty = 1'b1;
      logic [7:0] rdata, tx_data, w, pd;
      logic [7:0] pipe [4];
      logic [7:0] q [$];
      logic [7:0] sent [$];
      logic       pv;
      int         ren_cnt, hs_cnt;
`ifdef FIFO_RD_CTRL_CNT_EN
      logic [15:0] xfer_cnt;
`endif

      fifo_rd_ctrl #(.DATA_W(8), .RD_LAT(LAT), .CNT_W(16)) dut (
`ifdef FIFO_RD_CTRL_CNT_EN
         .o_xfer_cnt    (xfer_cnt),
`endif
         .clk           (clk),
         .rst           (rst),
         .i_enable      (en),
         .i_flush       (flush),
         .o_fifo_ren    (ren),
         .i_fifo_rempty (rempty),
         .i_fifo_rdata  (rdata),
         .o_tx_data     (tx_data),
         .o_tx_valid    (tx_valid),
         .i_tx_ready    (ready),
         .o_busy        (busy)
      );

      assign rdata = pipe[LAT-1];

      // FIFO pointer/RAM model: pop on ren, data emerges LAT cycles later, registered empty flag
      always @(posedge clk) begin
         w = 8'($urandom);
         if (rst) begin
            q.delete();
            sent.delete();
            rempty <= 1'b1;
         end else begin
            if (ren && q.size() != 0) w = q.pop_front();
            if (wr_en) begin
               q.push_back(wr_data);
               sent.push_back(wr_data);
            end
            rempty <= (q.size() == 0);
         end
         pipe[0] <= w;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end

      // protocol monitor and in-order scoreboard
      always @(negedge clk) begin
         if (rst) begin
            pv = 1'b0;
            ren_cnt = 0;
            hs_cnt = 0;
         end else begin
            if (pv) begin
               chk($sformatf("hold_valid%0d", g), tx_valid, 1);
               chk($sformatf("hold_data%0d", g), tx_data, pd);
            end
            if (ren) begin
               ren_cnt++;
               chk($sformatf("ren_while_empty%0d", g), rempty, 0);
            end
`ifdef FIFO_RD_CTRL_CNT_EN
            chk($sformatf("xfer_cnt%0d", g), xfer_cnt, hs_cnt);
`endif
            if (tx_valid && ready && !flush) begin
               hs_cnt++;
               chk($sformatf("hs_data%0d", g), tx_data, sent.size() != 0 ? {24'h0, sent.pop_front()} : 32'hx);
            end
            pv = tx_valid && !ready && !flush;
            pd = tx_data;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      chk("rst_ren0", u[0].ren, 0);
      chk("rst_ren1", u[1].ren, 0);
      chk("rst_valid0", u[0].tx_valid, 0);
      chk("rst_valid1", u[1].tx_valid, 0);
      chk("rst_data0", u[0].tx_data, 0);
      chk("rst_data1", u[1].tx_data, 0);
      chk("rst_busy0", u[0].busy, 0);
      chk("rst_busy1", u[1].busy, 0);
`ifdef FIFO_RD_CTRL_CNT_EN
      chk("rst_cnt0", u[0].xfer_cnt, 0);
      chk("rst_cnt1", u[1].xfer_cnt, 0);
`endif
      rst = 1'b0;
   endtask

   task automatic wait_both_valid();
      int n = 0;
      while (!(u[0].tx_valid && u[1].tx_valid) && n < 50) begin
         step();
         n++;
      end
      chk("valid_reached", {u[1].tx_valid, u[0].tx_valid}, 2'b11);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int l0, l1, n;
      logic [7:0] d0;
      do_reset();

      // single word: latency 2+RD_LAT after empty falls, one read strobe
      en = 1'b1;
      ready = 1'b1;
      write(8'hA5);
      l0 = -1;
      l1 = -1;
      d0 = 8'h00;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (l0 < 0 && u[0].tx_valid) begin
            l0 = k;
            d0 = u[0].tx_data;
         end
         if (l1 < 0 && u[1].tx_valid) l1 = k;
      end
      chk("lat_rd1", l0, 3);
      chk("lat_rd3", l1, 5);
      chk("data_a5", d0, 8'hA5);
      chk("single_ren0", u[0].ren_cnt, 1);
      chk("single_ren1", u[1].ren_cnt, 1);
      chk("single_idle0", u[0].busy, 0);
      chk("single_idle1", u[1].busy, 0);

      // backpressure: first word held through a 10-cycle stall, then all three in order
      do_reset();
      ready = 1'b0;
      write(8'h01);
      write(8'h02);
      write(8'h03);
      for (int k = 0; k < 10; k++) step();
      chk("stall_valid0", u[0].tx_valid, 1);
      chk("stall_data0", u[0].tx_data, 8'h01);
      chk("stall_data1", u[1].tx_data, 8'h01);
      chk("stall_ren0", u[0].ren_cnt, 1);
      chk("stall_ren1", u[1].ren_cnt, 1);
      ready = 1'b1;
      for (int k = 0; k < 40; k++) step();
      chk("bp_hs0", u[0].hs_cnt, 3);
      chk("bp_hs1", u[1].hs_cnt, 3);
`ifdef FIFO_RD_CTRL_CNT_EN
      chk("bp_cnt0", u[0].xfer_cnt, 3);
      chk("bp_cnt1", u[1].xfer_cnt, 3);
`endif

      // flush wins over a same-cycle handshake, then drains the remaining three words
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 4; k++) write(8'h10 + 8'(k));
      wait_both_valid();
      flush = 1'b1;
      ready = 1'b1;
      step();
      chk("flush_drop0", u[0].tx_valid, 0);
      chk("flush_drop1", u[1].tx_valid, 0);
      for (int k = 0; k < 9; k++) step();
      chk("flush_ren0", u[0].ren_cnt, 4);
      chk("flush_ren1", u[1].ren_cnt, 4);
      chk("flush_empty0", u[0].q.size(), 0);
      chk("flush_empty1", u[1].q.size(), 0);
      chk("flush_hs0", u[0].hs_cnt, 0);
`ifdef FIFO_RD_CTRL_CNT_EN
      chk("flush_cnt0", u[0].xfer_cnt, 0);
`endif
      flush = 1'b0;
      step();
      step();
      chk("flush_idle0", u[0].busy, 0);
      chk("flush_idle1", u[1].busy, 0);

      // enable dropped in VALID: held word completes, no further fetch
      do_reset();
      ready = 1'b0;
      for (int k = 0; k < 3; k++) write(8'h20 + 8'(k));
      wait_both_valid();
      en = 1'b0;
      for (int k = 0; k < 3; k++) step();
      chk("en_off_hold0", u[0].tx_valid, 1);
      chk("en_off_hold1", u[1].tx_valid, 1);
      ready = 1'b1;
      for (int k = 0; k < 15; k++) step();
      chk("en_off_hs0", u[0].hs_cnt, 1);
      chk("en_off_hs1", u[1].hs_cnt, 1);
      chk("en_off_ren0", u[0].ren_cnt, 1);
      chk("en_off_ren1", u[1].ren_cnt, 1);
      chk("en_off_left0", u[0].q.size(), 2);
      chk("en_off_busy1", u[1].busy, 0);

      // reset while RD_LAT=3 instance is in WAIT
      do_reset();
      en = 1'b1;
      ready = 1'b1;
      write(8'h5C);
      n = 0;
      while (!u[1].ren && n < 10) begin
         step();
         n++;
      end
      step();
      chk("mid_wait1", {u[1].busy, u[1].tx_valid}, 2'b10);
      do_reset();

      // randomized traffic, then drain and confirm every word delivered in order
      for (int i = 0; i < 2000; i++) begin
         en = ($urandom_range(7) != 0);
         ready = ($urandom_range(2) != 0);
         wr_en = ($urandom_range(7) == 0);
         wr_data = 8'($urandom);
         step();
      end
      wr_en = 1'b0;
      en = 1'b1;
      ready = 1'b1;
      n = 0;
      while ((u[0].sent.size() != 0 || u[1].sent.size() != 0 || u[0].busy || u[1].busy) && n < 4000) begin
         step();
         n++;
      end
      chk("drain_sent0", u[0].sent.size(), 0);
      chk("drain_sent1", u[1].sent.size(), 0);
      chk("drain_fifo0", u[0].q.size(), 0);
      chk("drain_fifo1", u[1].q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side sequencer for the UART TX FIFO. Pulls one word at a time through the FIFO read port (pointer plus synchronous RAM), absorbs the RAM read latency, and presents the word to the transmitter over a valid/ready handshake. It also provides a flush mode that discards all FIFO contents. It sits between the FIFO read pointer/RAM and the UART transmit serializer.

## Interface
- `DATA_W`, 8: FIFO word and TX data width.
- `RD_LAT`, 1: RAM read latency in cycles, from `o_fifo_ren` to `i_fifo_rdata` valid. Legal range 1..4.
- `CNT_W`, 16: width of the transfer counter. Used only with `FIFO_RD_CTRL_CNT_EN`.
- `clk  in  1` system clock; all logic on the rising edge.
- `rst  in  1` synchronous, active-high reset.
- `i_enable  in  1` permits new fetches.
- `i_flush  in  1` level; while high, discard FIFO contents.
- `o_fifo_ren  out  1` read strobe to the FIFO read pointer; one pulse per fetch.
- `i_fifo_rempty  in  1` registered empty flag from the read pointer.
- `i_fifo_rdata  in  DATA_W` RAM read data.
- `o_tx_data  out  DATA_W` held word to the transmitter.
- `o_tx_valid  out  1` `o_tx_data` is valid.
- `i_tx_ready  in  1` transmitter accepts the word.
- `o_busy  out  1` high in every state except IDLE.
- `o_xfer_cnt  out  CNT_W` completed handshakes. Present only with the macro.

## Operation
- FSM states are IDLE, FETCH, WAIT, VALID and FLUSH.
- **IDLE**
  - `i_flush` → FLUSH.
  - Otherwise `i_enable & ~i_fifo_rempty` → FETCH.
- **FETCH**
  - `o_fifo_ren=1` for exactly this cycle.
  - Load the latency counter with `RD_LAT-1`.
  - → WAIT.
- **WAIT**
  - Lasts `RD_LAT` cycles; the counter decrements each cycle.
  - In the last WAIT cycle, `i_fifo_rdata` is captured into `o_tx_data`.
  - If `i_flush` was sampled high at any point during FETCH or WAIT, the word is discarded and the next state is FLUSH.
  - Otherwise → VALID.
- **VALID**
  - `o_tx_valid=1`; `o_tx_data` is stable until the handshake.
  - On `o_tx_valid & i_tx_ready` with `i_flush=0`:
    - → FETCH if `i_enable & ~i_fifo_rempty`.
    - Otherwise → IDLE.
  - `i_flush=1` → FLUSH. This wins over a same-cycle handshake: the word is dropped, no transfer is counted, and `o_tx_valid` is low next cycle.
  - Deasserting `i_enable` does not abort VALID; the held word still completes.
- **FLUSH**
  - `o_fifo_ren = ~i_fifo_rempty` every cycle; `o_fifo_ren` is never asserted while `i_fifo_rempty=1`.
  - Returned data is ignored.
  - `i_flush=0` → IDLE.
- `o_fifo_ren` is never asserted in IDLE, WAIT or VALID.
- The latency counter is 2 bits wide and does not wrap.

## Timing
- Reset values: state IDLE, `o_fifo_ren=0`, `o_tx_valid=0`, `o_tx_data=0`, `o_busy=0`, `o_xfer_cnt=0`.
- Reset mid-operation: next cycle all of the above. A word held in VALID is lost.
- Empty to first valid: with `i_fifo_rempty` low in cycle N (IDLE, enabled):
  - FETCH in N+1.
  - WAIT in N+2..N+1+`RD_LAT`.
  - `o_tx_valid` high in N+2+`RD_LAT`.
- Back-to-back transfers: handshake in cycle M with data available → next `o_tx_valid` in M+2+`RD_LAT`.
- `o_tx_valid` and `o_tx_data` are registered.
- `o_fifo_ren` is a decode of registered state gated by `i_fifo_rempty` (FLUSH only), so it is glitch-free.
- The last word read empties the FIFO. `i_fifo_rempty` rises the cycle after FETCH, so the VALID exit decision always sees the updated flag.

## Configuration
- `FIFO_RD_CTRL_CNT_EN` defined:
  - `o_xfer_cnt` port exists.
  - Increments by 1 on each accepted handshake that is not pre-empted by flush.
  - Wraps modulo 2^`CNT_W`; reset to 0.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `fifo_rd_ctrl_pkg`:
  - `state_e` enum (IDLE, FETCH, WAIT, VALID, FLUSH).
  - `RD_LAT_MAX = 4`.
- No sub-module. The FIFO read pointer and RAM are instantiated alongside in the FIFO top.
- An elaboration-time assertion rejects `RD_LAT` outside 1..4.

## Test plan
- Single word, `RD_LAT=1`:
  - Stimulus: write 0xA5; `i_enable=1`; `i_tx_ready=1`.
  - Required: one `o_fifo_ren` pulse; `o_tx_valid` 3 cycles after `i_fifo_rempty` falls; `o_tx_data=0xA5`; return to IDLE; `o_busy` low.
- Backpressure:
  - Stimulus: words 0x01,0x02,0x03; `i_tx_ready` low for 10 cycles, then high.
  - Required: `o_tx_data` held at 0x01 throughout the stall; no extra `o_fifo_ren`; outputs in order 0x01,0x02,0x03; with macro, `o_xfer_cnt=3`.
- `RD_LAT=3`:
  - Stimulus: a single word.
  - Required: exactly 3 WAIT cycles; data captured in the last one; `o_tx_valid` 5 cycles after IDLE sees non-empty.
- Flush in VALID with same-cycle ready:
  - Stimulus: 4 words queued; assert `i_flush` on the first handshake cycle.
  - Required: word dropped; `o_xfer_cnt` unchanged; 3 `o_fifo_ren` pulses; FIFO empty; no underflow; IDLE after `i_flush` drops.
- Enable off / reset mid-WAIT:
  - Stimulus: deassert `i_enable` in VALID with 2 words left.
  - Required: the current word completes, then IDLE with no further fetch.
  - Stimulus: assert `rst` during WAIT.
  - Required: all outputs at reset values next cycle.
